pipe_stage_skid: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake, a 2-entry skid buffer, synchronous flush and a stall-cycle counter. It is the general stage-boundary block for the core (IF/ID, ID/EX, EX/MEM, MEM/WB), replacing fixed-field, always-load registers. It carries an opaque data payload plus a control field that is forced to zero on bubbles and flushes. This guarantees that an empty slot never asserts write enables downstream.

---
 rtl/pipe_stage_skid.sv | 143 ++++++++++++++
 tb/tb_pipe_stage_skid.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: pipeline stage register with valid/ready handshake,
// a two-entry skid buffer (main + skid), synchronous flush and a
// saturating back-pressure counter.
//
// The main entry drives the outputs straight from flops. The skid entry
// catches the one beat that can arrive in the cycle after out_ready drops.
// in_ready is simply "skid is empty", so it never depends
// combinationally on out_ready. Control bits are zeroed whenever an entry
// becomes empty, so a bubble can never carry a live write enable downstream.
module pipe_stage_skid #(
    parameter int DATA_W = 101,
    parameter int CTRL_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cycles
);

    // State value doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t              state_q;
    logic                main_valid_q;
    logic [DATA_W-1:0]   main_data_q;
    logic [CTRL_W-1:0]   main_ctrl_q;
    logic                skid_valid_q;
    logic [DATA_W-1:0]   skid_data_q;
    logic [CTRL_W-1:0]   skid_ctrl_q;
    logic [CNT_W-1:0]    stall_q;
    logic [CNT_W-1:0]    stall_d;

    logic accept;
    logic pop;

    // Handshake events; in_ready comes from a flop, so accept has no
    // path from out_ready.
    assign accept = in_valid & ~skid_valid_q;
    assign pop    = main_valid_q & out_ready;

    // Stage FSM: owns both entries. Flush beats every transition; a beat
    // accepted in the flush cycle is dropped, a pop in that cycle completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= EMPTY;
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_ctrl_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_ctrl_q  <= '0;
        end else if (flush) begin
            // Data registers are left stale; only valid and ctrl matter.
            state_q      <= EMPTY;
            main_valid_q <= 1'b0;
            main_ctrl_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_q      <= ONE;
                        main_valid_q <= 1'b1;
                        main_data_q  <= in_data;
                        main_ctrl_q  <= in_ctrl;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        // Pass-through: new beat replaces the one leaving.
                        main_data_q <= in_data;
                        main_ctrl_q <= in_ctrl;
                    end else if (accept) begin
                        // Downstream stalled: park the new beat in skid.
                        state_q      <= FULL;
                        skid_valid_q <= 1'b1;
                        skid_data_q  <= in_data;
                        skid_ctrl_q  <= in_ctrl;
                    end else if (pop) begin
                        state_q      <= EMPTY;
                        main_valid_q <= 1'b0;
                        main_ctrl_q  <= '0;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a pop can move things.
                    if (pop) begin
                        state_q      <= ONE;
                        main_data_q  <= skid_data_q;
                        main_ctrl_q  <= skid_ctrl_q;
                        skid_valid_q <= 1'b0;
                        skid_ctrl_q  <= '0;
                    end
                end
                default: begin
                    state_q      <= EMPTY;
                    main_valid_q <= 1'b0;
                    main_ctrl_q  <= '0;
                    skid_valid_q <= 1'b0;
                    skid_ctrl_q  <= '0;
                end
            endcase
        end
    end

    // Next stall count: bump on every back-pressured cycle, stick at max.
    always_comb begin
        stall_d = stall_q;
        if (main_valid_q && !out_ready && (stall_q != CNT_MAX))
            stall_d = stall_q + 1'b1;
    end

    // Stall counter register; only reset clears it, flush does not.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_q <= '0;
        else       stall_q <= stall_d;
    end

    assign in_ready     = ~skid_valid_q;
    assign out_valid    = main_valid_q;
    assign out_data     = main_data_q;
    assign out_ctrl     = main_ctrl_q;
    assign occupancy    = state_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Testbench for pipe_stage_skid: directed vectors, expected beats pushed
// by the driver into a queue, a monitor pops and compares on every pop.
module tb_pipe_stage_skid;

    localparam int DW = 101;
    localparam int CW = 3;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [1:0]    occupancy;
    logic [NW-1:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    logic [DW+CW-1:0] exp_q[$];

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ctrl(out_ctrl),
        .occupancy(occupancy), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat until accepted (bounded), record it as expected output.
    task automatic send(input logic [DW-1:0] d, input logic [CW-1:0] c);
        bit done;
        done = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_ctrl  = c;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({d, c});
                done = 1;
            end
            cyc();
        end
        if (!done) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    // Monitor: every completed transfer must match the oldest expected beat.
    initial begin
        logic [DW+CW-1:0] e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_beat", {out_data, out_ctrl}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", out_data, e[DW+CW-1:CW]);
                    chk("beat_ctrl", out_ctrl, e[CW-1:0]);
                end
            end
        end
    end

    initial begin
        // Power-on reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_ctrl", out_ctrl, 0);
        chk("rst_data", out_data, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_rdy", in_ready, 1);
        chk("rst_stall", stall_cycles, 0);
        reset = 1'b0;
        cyc();

        // Streaming: 8 beats back to back with out_ready held high.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i);
            in_ctrl  = 3'b101;
            @(negedge clk);
            chk("stream_rdy", in_ready, 1);
            exp_q.push_back({DW'(i), 3'b101});
            if (i > 1) chk("stream_occ", occupancy, 1);
            if (i == 2) chk("stream_latency", out_valid, 1);
            cyc();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream_tail_occ", occupancy, 1);
        cyc();
        @(negedge clk);
        chk("stream_drained", occupancy, 0);
        chk("stream_stall", stall_cycles, 0);
        chk("stream_q", exp_q.size(), 0);
        cyc();

        // Back-pressure: A to main, B to skid, C held upstream.
        out_ready = 1'b0;
        send(DW'('hA), 3'd1);
        send(DW'('hB), 3'd2);
        in_valid = 1'b1;
        in_data  = DW'('hC);
        in_ctrl  = 3'd3;
        @(negedge clk);
        chk("bp_rdy", in_ready, 0);
        chk("bp_occ", occupancy, 2);
        chk("bp_main_data", out_data, 'hA);
        chk("bp_main_ctrl", out_ctrl, 1);
        cyc();
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_rdy_still_low", in_ready, 0);
        cyc();
        @(negedge clk);
        chk("bp_rdy_back", in_ready, 1);
        exp_q.push_back({DW'('hC), 3'd3});
        cyc();
        in_valid = 1'b0;
        repeat (3) cyc();
        @(negedge clk);
        chk("bp_drained", occupancy, 0);
        chk("bp_q", exp_q.size(), 0);
        cyc();

        // Flush while FULL, with a beat offered in the same cycle.
        out_ready = 1'b0;
        send(DW'('hD), 3'd4);
        send(DW'('hE), 3'd5);
        in_valid = 1'b1;
        in_data  = DW'('hF);
        in_ctrl  = 3'd7;
        flush    = 1'b1;
        @(negedge clk);
        chk("fl_pre_occ", occupancy, 2);
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("fl_occ", occupancy, 0);
        chk("fl_valid", out_valid, 0);
        chk("fl_ctrl", out_ctrl, 0);
        chk("fl_rdy", in_ready, 1);
        out_ready = 1'b1;
        repeat (3) cyc();

        // Flush in ONE: pop completes, the accepted beat H is dropped.
        out_ready = 1'b0;
        send(DW'('h10), 3'd6);
        in_valid  = 1'b1;
        in_data   = DW'('h11);
        in_ctrl   = 3'd7;
        flush     = 1'b1;
        out_ready = 1'b1;
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl1_q", exp_q.size(), 0);
        @(negedge clk);
        chk("fl1_occ", occupancy, 0);
        chk("fl1_valid", out_valid, 0);
        repeat (2) cyc();

        // Bubble: ctrl driven without valid never reaches the output.
        in_ctrl = 3'b111;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bubble_ctrl", out_ctrl, 0);
            chk("bubble_valid", out_valid, 0);
            cyc();
        end

        // Asynchronous reset mid-stream with occupancy 2.
        out_ready = 1'b0;
        send(DW'('h21), 3'd1);
        send(DW'('h22), 3'd2);
        chk("ar_pre_occ", occupancy, 2);
        chk("ar_pre_stall", stall_cycles == 0, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_ctrl", out_ctrl, 0);
        chk("ar_occ", occupancy, 0);
        chk("ar_rdy", in_ready, 1);
        chk("ar_stall", stall_cycles, 0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        cyc();

        // Counter saturation: 4-bit counter pinned at 15.
        out_ready = 1'b0;
        send(DW'('h5A), 3'd6);
        for (int j = 0; j <= 20; j++) begin
            @(negedge clk);
            chk("sat_count", stall_cycles, (j > 15) ? 15 : j);
            cyc();
        end
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("sat_after_flush", stall_cycles, 15);
        chk("sat_flush_occ", occupancy, 0);
        out_ready = 1'b1;
        repeat (3) cyc();

        chk("final_q", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
